// File: rtl/input_conditioner_if.sv
// Button-in / command-out bundle between the raw button pins and the fsm stage.
// slave = conditioner side, master = pin/consumer side.
interface input_conditioner_if;
  logic [2:0] btn_raw;
  logic [2:0] user_input;
  logic [2:0] press_pulse;
  logic       cmd_valid;
  logic [1:0] cmd_code;

  modport master (
    output btn_raw,
    input  user_input,
    input  press_pulse,
    input  cmd_valid,
    input  cmd_code
  );

  modport slave (
    input  btn_raw,
    output user_input,
    output press_pulse,
    output cmd_valid,
    output cmd_code
  );
endinterface

// File: rtl/input_conditioner.sv
// Syncs and debounces 3 button lines into user_input (SYNC_STAGES+DEBOUNCE_CYCLES lag), then one-cycle press pulses + priority cmd strobe.
// Free-running strobes, no backpressure. Define INPUT_COND_REPEAT_EN for held-button auto-repeat.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input_conditioner_if.slave bus
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("input_conditioner: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]                  sync_s;
  logic [2:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [2:0]                  level_q, level_d;
  logic [2:0]                  level_dly_q, level_dly_d;
  logic [2:0]                  rise;
  logic [2:0]                  pulse_q, pulse_d;
  logic                        cmd_valid_q, cmd_valid_d;
  logic [1:0]                  cmd_code_q, cmd_code_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
  end

  // Any sample matching the stable level wipes the count: glitches earn no partial credit.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync_s[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        level_d[i]  = ~level_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    level_dly_d = level_q;
    rise        = level_q & ~level_dly_q;
  end

`ifdef INPUT_COND_REPEAT_EN
  localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RPT_W     = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

  logic [2:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [2:0]            rpt_armed_q, rpt_armed_d;
  logic [2:0]            rpt_fire;

  // Count restarts at 1 on every emitted pulse, so a match at N lands the next pulse N cycles later.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_fire    = '0;
    for (int i = 0; i < 3; i++) begin
      if (!level_q[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_armed_d[i] = 1'b0;
      end else if (rise[i]) begin
        rpt_cnt_d[i]   = RPT_W'(1);
        rpt_armed_d[i] = 1'b0;
      end else if (rpt_cnt_q[i] != '0) begin
        if (rpt_cnt_q[i] == (rpt_armed_q[i] ? RPT_NEXT : RPT_FIRST)) begin
          rpt_fire[i]    = 1'b1;
          rpt_cnt_d[i]   = RPT_W'(1);
          rpt_armed_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= '0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  always_comb begin
    pulse_d = rise | rpt_fire;
  end
`else
  always_comb begin
    pulse_d = rise;
  end
`endif

  always_comb begin
    cmd_valid_d = |pulse_d;
    cmd_code_d  = 2'd0;
    if (pulse_d[0]) begin
      cmd_code_d = 2'd0;
    end else if (pulse_d[1]) begin
      cmd_code_d = 2'd1;
    end else if (pulse_d[2]) begin
      cmd_code_d = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 2'd0;
    end else begin
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign bus.user_input  = level_q;
  assign bus.press_pulse = pulse_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_code    = cmd_code_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: tasks push expected pulses, a negedge monitor pops and compares.
module tb_input_conditioner;

  localparam int RPT_DELAY  = 8;
  localparam int RPT_PERIOD = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  input_conditioner_if ifc();

  input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (RPT_DELAY),
    .REPEAT_PERIOD  (RPT_PERIOD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  typedef struct {
    int         cyc;
    logic [2:0] bits;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc++;

  function automatic logic [1:0] low_code(input logic [2:0] b);
    if (b[0]) return 2'd0;
    if (b[1]) return 2'd1;
    return 2'd2;
  endfunction

  // Initial pulse at p, plus auto-repeats while the level is still high (fall = edge the level drops).
  task automatic push_press(input int p, input logic [2:0] bits, input int fall);
    exp_t e;
    e.cyc  = p;
    e.bits = bits;
    e.code = low_code(bits);
    exp_q.push_back(e);
`ifdef INPUT_COND_REPEAT_EN
    for (int t = p + RPT_DELAY; t < fall; t += RPT_PERIOD) begin
      e.cyc = t;
      exp_q.push_back(e);
    end
`else
    if (fall < p) $display("note: fall edge %0d precedes pulse %0d", fall, p);
`endif
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse cyc=%0d got=none exp=%b@%0d", cyc, exp_q[0].bits, exp_q[0].cyc);
        exp_q.delete(0);
      end
      checks++;
      if (ifc.press_pulse !== 3'b000 || ifc.cmd_valid !== 1'b0) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got pulse=%b valid=%b exp=none", cyc, ifc.press_pulse, ifc.cmd_valid);
        end else begin
          e = exp_q[0];
          exp_q.delete(0);
          if (ifc.press_pulse !== e.bits || ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== e.code) begin
            errors++;
            $display("FAIL pulse_cmd cyc=%0d got pulse=%b valid=%b code=%0d exp pulse=%b valid=1 code=%0d",
                     cyc, ifc.press_pulse, ifc.cmd_valid, ifc.cmd_code, e.bits, e.code);
          end
        end
      end else if (ifc.cmd_code !== 2'd0) begin
        errors++;
        $display("FAIL idle_code cyc=%0d got=%0d exp=0", cyc, ifc.cmd_code);
      end
    end
  end

  task automatic test_reset();
    int n;
    rst_n       = 1'b1;
    ifc.btn_raw = 3'b111;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.user_input, ifc.press_pulse, ifc.cmd_valid, ifc.cmd_code} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {ifc.user_input, ifc.press_pulse, ifc.cmd_valid, ifc.cmd_code});
    end
    rst_n = 1'b1;
    n = cyc;
    push_press(n + 7, 3'b111, n + 13);
    wait_to(n + 5);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL reset_early_level got=%b exp=000", ifc.user_input);
    end
    wait_to(n + 6);
    checks++;
    if (ifc.user_input !== 3'b111) begin
      errors++;
      $display("FAIL reset_held_level got=%b exp=111", ifc.user_input);
    end
    wait_to(n + 7);
    ifc.btn_raw = 3'b000;
    wait_to(n + 13);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_level got=%b exp=000", ifc.user_input);
    end
  endtask

  task automatic test_single_press();
    int n = cyc;
    ifc.btn_raw = 3'b010;
    push_press(n + 7, 3'b010, n + 26);
    wait_to(n + 5);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL press_early got=%b exp=000", ifc.user_input);
    end
    wait_to(n + 6);
    checks++;
    if (ifc.user_input !== 3'b010) begin
      errors++;
      $display("FAIL press_level got=%b exp=010", ifc.user_input);
    end
    wait_to(n + 20);
    ifc.btn_raw = 3'b000;
    wait_to(n + 25);
    checks++;
    if (ifc.user_input !== 3'b010) begin
      errors++;
      $display("FAIL release_early got=%b exp=010", ifc.user_input);
    end
    wait_to(n + 26);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL release_level got=%b exp=000", ifc.user_input);
    end
    wait_to(n + 30);
  endtask

  task automatic test_glitch();
    int n = cyc;
    ifc.btn_raw = 3'b001;
    for (int k = 1; k <= 14; k++) begin
      wait_to(n + k);
      if (k == 3) ifc.btn_raw = 3'b000;
      checks++;
      if (ifc.user_input !== 3'b000) begin
        errors++;
        $display("FAIL glitch_level k=%0d got=%b exp=000", k, ifc.user_input);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n = cyc;
    ifc.btn_raw = 3'b101;
    push_press(n + 7, 3'b101, n + 16);
    wait_to(n + 6);
    checks++;
    if (ifc.user_input !== 3'b101) begin
      errors++;
      $display("FAIL simul_level got=%b exp=101", ifc.user_input);
    end
    wait_to(n + 10);
    ifc.btn_raw = 3'b000;
    wait_to(n + 16);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL simul_release got=%b exp=000", ifc.user_input);
    end
    wait_to(n + 20);
  endtask

  task automatic test_reset_midcount();
    int n = cyc;
    int m;
    ifc.btn_raw = 3'b100;
    push_press(n + 7, 3'b100, n + 12);
    wait_to(n + 6);
    checks++;
    if (ifc.user_input !== 3'b100) begin
      errors++;
      $display("FAIL mid_pre_level got=%b exp=100", ifc.user_input);
    end
    wait_to(n + 8);
    ifc.btn_raw = 3'b110;
    wait_to(n + 12);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.user_input, ifc.press_pulse, ifc.cmd_valid, ifc.cmd_code} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%b exp=0", {ifc.user_input, ifc.press_pulse, ifc.cmd_valid, ifc.cmd_code});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m = cyc;
    push_press(m + 7, 3'b110, m + 14);
    wait_to(m + 5);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL mid_restart_early got=%b exp=000", ifc.user_input);
    end
    wait_to(m + 6);
    checks++;
    if (ifc.user_input !== 3'b110) begin
      errors++;
      $display("FAIL mid_restart_level got=%b exp=110", ifc.user_input);
    end
    wait_to(m + 8);
    ifc.btn_raw = 3'b000;
    wait_to(m + 14);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL mid_release got=%b exp=000", ifc.user_input);
    end
    wait_to(m + 18);
  endtask

  task automatic test_repeat();
    int n = cyc;
    ifc.btn_raw = 3'b100;
    push_press(n + 7, 3'b100, n + 36);
    wait_to(n + 30);
    checks++;
    if (ifc.user_input !== 3'b100) begin
      errors++;
      $display("FAIL repeat_held got=%b exp=100", ifc.user_input);
    end
    ifc.btn_raw = 3'b000;
    wait_to(n + 36);
    checks++;
    if (ifc.user_input !== 3'b000) begin
      errors++;
      $display("FAIL repeat_release got=%b exp=000", ifc.user_input);
    end
    wait_to(n + 46);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_repeat();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
